fetch_unit: RTL
===============

# fetch_unit

Parametrised successor to the single-cycle fetch stage. Generates the PC stream, looks up a direct-mapped branch target buffer with 2-bit saturating counters, and issues one-outstanding instruction memory requests. Buffers returned instructions in a fetch queue that drains to decode through a valid/ready handshake. Handles iret, exception and mispredict redirects with queue flush and in-flight response squash.

## Interface
- XLEN, 32, address/instruction width
- RESET_PC, 32'h1000, PC after reset
- EXC_VECTOR, 32'h2000, PC loaded on exception
- BTB_IDX_W, 4, BTB index bits (2**BTB_IDX_W entries)
- FQ_DEPTH, 4, fetch queue entries (power of two, ≥2)

- clk_i  in  1  clock; all state updates on rising edge
- rsn_i  in  1  reset, synchronous, active-low
- iret_i  in  1  return from exception
- exc_return_pc_i  in  XLEN  faulting PC; fetch resumes at this +4
- exc_occured_i  in  1  exception redirect
- redirect_i  in  1  branch mispredict redirect
- redirect_pc_i  in  XLEN  corrected PC
- upd_valid_i  in  1  BTB update from ALU
- upd_pc_i  in  XLEN  branch PC
- upd_taken_i  in  1  resolved direction
- upd_target_i  in  XLEN  resolved target
- imem_req_o  out  1  request valid
- imem_addr_o  out  XLEN  request address (= PC)
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response valid
- imem_rdata_i  in  XLEN  response instruction
- fq_valid_o  out  1  queue head valid
- fq_ready_i  in  1  decode accepts head
- pc_o, instr_o, pred_pc_o  out  XLEN  head entry fields
- taken_o  out  1  head predicted taken

## Operation
- Redirect priority: iret_i (PC ← exc_return_pc_i+4) > exc_occured_i (PC ← EXC_VECTOR) > redirect_i (PC ← redirect_pc_i). Any redirect: flush queue (count ← 0), set squash if a request is outstanding, suppress imem_req_o that cycle.
- Request: imem_req_o = !redirect && !outstanding && (count + outstanding < FQ_DEPTH). On req&&gnt: outstanding ← 1, latch PC and prediction, PC ← predicted next.
- Predicted next: BTB hit (valid && tag == pc[XLEN-1:2+BTB_IDX_W]) && ctr[1] → target, taken=1; else PC+4 (modulo 2**XLEN), taken=0, pred_pc = PC+4.
- Response: on imem_rvalid_i, outstanding ← 0. If squash or redirect this cycle: discard, squash ← 0. Else push {pc, instr, taken, pred_pc}.
- Pop on fq_valid_o && fq_ready_i. Push and pop same cycle legal at any count. Pointers wrap modulo FQ_DEPTH; push never occurs when full (credit rule).
- BTB update: hit → ctr ±1 saturating at 0/3, target rewritten if taken. Miss && taken → allocate {valid, tag, target, ctr=2'b10}. Miss && not taken → no change.
- Reset: PC ← RESET_PC; all BTB valid and ctr ← 0; count, pointers, outstanding, squash ← 0.

## Timing
- Reset values: imem_req_o=1 only from first cycle after rsn_i high (0 while rsn_i=0); imem_addr_o=RESET_PC; fq_valid_o=0; pc_o/instr_o/pred_pc_o=0; taken_o=0.
- BTB lookup combinational on current PC; update visible next cycle. Same-index lookup and update same cycle: lookup sees old entry.
- Redirect in cycle N → imem_req_o with new PC in N+1.
- Response at cycle N → fq_valid_o in N+1 (no bypass).
- Minimum memory latency: response no earlier than cycle after grant. Throughput ≤ one instruction per two cycles.
- Reset asserted mid-transaction: outstanding cleared; a late response after reset is ignored (outstanding=0).
- Outputs hold while fq_valid_o && !fq_ready_i.

## Test plan
- Reset, gnt=1, rvalid one cycle after grant, ready=1, empty BTB → addresses 0x1000, 0x1004, 0x1008; instr_o matches, taken_o=0.
- BTB update pc=0x1008 taken target=0x1100 twice → next fetch of 0x1008 yields taken_o=1, pred_pc_o=0x1100, next request 0x1100; two not-taken updates → taken_o=0.
- ready=0 with FQ_DEPTH=4 → exactly 4 entries fill, imem_req_o=0; release ready → drain in order, requests resume.
- redirect_i pc=0x3000 while request outstanding → queue flushed, returning response discarded, next request 0x3000.
- iret_i, exc_occured_i, redirect_i same cycle, exc_return_pc=0x1234 → next request 0x1238; exc_occured_i alone → 0x2000.
- rsn_i low mid-run with queue full → fq_valid_o=0, next request 0x1000, BTB predicts not taken for previously trained PCs.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, direct-mapped BTB prediction, single-outstanding
// instruction fetch and a fetch queue draining to decode via valid/ready.
module fetch_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h1000,
    parameter logic [XLEN-1:0] EXC_VECTOR = 32'h2000,
    parameter int unsigned     BTB_IDX_W  = 4,
    parameter int unsigned     FQ_DEPTH   = 4
) (
    input  logic            clk_i,
    input  logic            rsn_i,
    input  logic            iret_i,
    input  logic [XLEN-1:0] exc_return_pc_i,
    input  logic            exc_occured_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            fq_valid_o,
    input  logic            fq_ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pred_pc_o,
    output logic            taken_o
);

    localparam int unsigned BTB_N = 1 << BTB_IDX_W;
    localparam int unsigned TAG_W = XLEN - 2 - BTB_IDX_W;
    localparam int unsigned PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    // fetch state
    logic [XLEN-1:0] pc_q, pc_d;
    logic            out_q, out_d;
    logic            squash_q, squash_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] req_pred_q, req_pred_d;
    logic            req_taken_q, req_taken_d;

    // branch target buffer
    logic [BTB_N-1:0]                 btb_valid_q, btb_valid_d;
    logic [BTB_N-1:0][1:0]            btb_ctr_q, btb_ctr_d;
    logic [BTB_N-1:0][TAG_W-1:0]      btb_tag_q, btb_tag_d;
    logic [BTB_N-1:0][XLEN-1:0]       btb_tgt_q, btb_tgt_d;

    // fetch queue
    logic [FQ_DEPTH-1:0][XLEN-1:0]    fq_pc_q, fq_pc_d;
    logic [FQ_DEPTH-1:0][XLEN-1:0]    fq_instr_q, fq_instr_d;
    logic [FQ_DEPTH-1:0][XLEN-1:0]    fq_pred_q, fq_pred_d;
    logic [FQ_DEPTH-1:0]              fq_taken_q, fq_taken_d;
    logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                 count_q, count_d;

    // combinational helpers
    logic [BTB_IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0]     lk_tag, up_tag;
    logic                 lk_hit, up_hit;
    logic                 pred_taken;
    logic [XLEN-1:0]      pred_next;
    logic                 redirect_any;
    logic                 credit_ok;
    logic                 req_c;
    logic                 rsp_accept;
    logic                 push, pop;
    logic                 unused_upd_lsb;

    assign unused_upd_lsb = ^upd_pc_i[1:0];

    // BTB lookup on the current PC and tag check for the update port
    always_comb begin
        lk_idx     = pc_q[2 +: BTB_IDX_W];
        lk_tag     = pc_q[XLEN-1 -: TAG_W];
        lk_hit     = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
        pred_taken = lk_hit && btb_ctr_q[lk_idx][1];
        pred_next  = pred_taken ? btb_tgt_q[lk_idx] : (pc_q + XLEN'(4));
        up_idx     = upd_pc_i[2 +: BTB_IDX_W];
        up_tag     = upd_pc_i[XLEN-1 -: TAG_W];
        up_hit     = btb_valid_q[up_idx] && (btb_tag_q[up_idx] == up_tag);
    end

    // next-state: redirects, request issue, response capture, queue and BTB update
    always_comb begin
        pc_d        = pc_q;
        out_d       = out_q;
        squash_d    = squash_q;
        req_pc_d    = req_pc_q;
        req_pred_d  = req_pred_q;
        req_taken_d = req_taken_q;
        btb_valid_d = btb_valid_q;
        btb_ctr_d   = btb_ctr_q;
        btb_tag_d   = btb_tag_q;
        btb_tgt_d   = btb_tgt_q;
        fq_pc_d     = fq_pc_q;
        fq_instr_d  = fq_instr_q;
        fq_pred_d   = fq_pred_q;
        fq_taken_d  = fq_taken_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        redirect_any = iret_i || exc_occured_i || redirect_i;
        credit_ok    = ({1'b0, count_q} + (CNT_W+1)'(out_q)) < (CNT_W+1)'(FQ_DEPTH);
        req_c        = rsn_i && !redirect_any && !out_q && credit_ok;
        rsp_accept   = imem_rvalid_i && out_q;
        push         = rsp_accept && !squash_q && !redirect_any;
        pop          = (count_q != '0) && fq_ready_i;

        // a response ends the outstanding request and clears any pending squash
        if (rsp_accept) begin
            out_d    = 1'b0;
            squash_d = 1'b0;
        end

        if (req_c && imem_gnt_i) begin
            out_d       = 1'b1;
            req_pc_d    = pc_q;
            req_pred_d  = pred_next;
            req_taken_d = pred_taken;
            pc_d        = pred_next;
        end

        if (push) begin
            fq_pc_d[wr_ptr_q]    = req_pc_q;
            fq_instr_d[wr_ptr_q] = imem_rdata_i;
            fq_pred_d[wr_ptr_q]  = req_pred_q;
            fq_taken_d[wr_ptr_q] = req_taken_q;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        // redirect flushes the queue; a request still in flight gets squashed
        if (redirect_any) begin
            if (iret_i) begin
                pc_d = exc_return_pc_i + XLEN'(4);
            end else if (exc_occured_i) begin
                pc_d = EXC_VECTOR;
            end else begin
                pc_d = redirect_pc_i;
            end
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            squash_d = out_q && !rsp_accept;
        end

        // counter training; allocate only on a taken miss
        if (upd_valid_i) begin
            if (up_hit) begin
                if (upd_taken_i) begin
                    if (btb_ctr_q[up_idx] != 2'b11) begin
                        btb_ctr_d[up_idx] = btb_ctr_q[up_idx] + 2'd1;
                    end
                    btb_tgt_d[up_idx] = upd_target_i;
                end else if (btb_ctr_q[up_idx] != 2'b00) begin
                    btb_ctr_d[up_idx] = btb_ctr_q[up_idx] - 2'd1;
                end
            end else if (upd_taken_i) begin
                btb_valid_d[up_idx] = 1'b1;
                btb_tag_d[up_idx]   = up_tag;
                btb_tgt_d[up_idx]   = upd_target_i;
                btb_ctr_d[up_idx]   = 2'b10;
            end
        end
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            pc_q        <= RESET_PC;
            out_q       <= 1'b0;
            squash_q    <= 1'b0;
            req_pc_q    <= '0;
            req_pred_q  <= '0;
            req_taken_q <= 1'b0;
            btb_valid_q <= '0;
            btb_ctr_q   <= '0;
            btb_tag_q   <= '0;
            btb_tgt_q   <= '0;
            fq_pc_q     <= '0;
            fq_instr_q  <= '0;
            fq_pred_q   <= '0;
            fq_taken_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            pc_q        <= pc_d;
            out_q       <= out_d;
            squash_q    <= squash_d;
            req_pc_q    <= req_pc_d;
            req_pred_q  <= req_pred_d;
            req_taken_q <= req_taken_d;
            btb_valid_q <= btb_valid_d;
            btb_ctr_q   <= btb_ctr_d;
            btb_tag_q   <= btb_tag_d;
            btb_tgt_q   <= btb_tgt_d;
            fq_pc_q     <= fq_pc_d;
            fq_instr_q  <= fq_instr_d;
            fq_pred_q   <= fq_pred_d;
            fq_taken_q  <= fq_taken_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    assign imem_req_o  = req_c;
    assign imem_addr_o = pc_q;
    assign fq_valid_o  = (count_q != '0);
    assign pc_o        = fq_pc_q[rd_ptr_q];
    assign instr_o     = fq_instr_q[rd_ptr_q];
    assign pred_pc_o   = fq_pred_q[rd_ptr_q];
    assign taken_o     = fq_taken_q[rd_ptr_q];

endmodule
